// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB next-PC predictor for the IF stage.
// Ports: clk/rst_n (async active-low); stall_i freezes the table; flush_i clears all valid bits;
//   if_pc -> pred_hit/pred_taken/next_pc (combinational lookup);
//   upd_* resolution updates from ID, written at posedge when !stall_i && !flush_i;
//   stat_updates/stat_mispredicts counters, present only when BTP_STATS_EN is defined (else 0).
module branch_target_predictor #(
    parameter int BTB_ENTRIES = 16,
    parameter int TAG_W       = 8,
    parameter int CNT_W       = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] if_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] next_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_is_jump,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispredicts
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_ONE << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_ONE;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [29:0]            target_q [BTB_ENTRIES];
    logic [CNT_W-1:0]       cnt_q    [BTB_ENTRIES];
    logic [BTB_ENTRIES-1:0] jmp_q;

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             u_hit, upd_acc, flush_en;
    logic [CNT_W-1:0] cnt_d;

    assign l_idx = if_pc[IDX_W+1:2];
    assign l_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    assign pred_hit   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign pred_taken = pred_hit && (jmp_q[l_idx] || cnt_q[l_idx][CNT_W-1]);
    assign next_pc    = pred_taken ? {target_q[l_idx], 2'b00} : if_pc + 32'd4;

    assign flush_en = flush_i && !stall_i;
    assign upd_acc  = upd_valid && !stall_i && !flush_i;
    assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // Counter next value for the indexed entry; only meaningful when an update is written.
    always_comb begin
        cnt_d = cnt_q[u_idx];
        if (upd_taken)
            cnt_d = upd_is_jump ? CNT_MAX : !u_hit ? CNT_WT :
                    (cnt_q[u_idx] == CNT_MAX) ? CNT_MAX : cnt_q[u_idx] + CNT_ONE;
        else
            cnt_d = (cnt_q[u_idx] == '0) ? '0 : cnt_q[u_idx] - CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            jmp_q   <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WNT;
            end
        end else if (flush_en) begin
            valid_q <= '0;
        end else if (upd_acc && upd_taken) begin
            // Taken updates both refresh a hit and allocate over any alias on a miss.
            valid_q[u_idx]  <= 1'b1;
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= upd_target[31:2];
            jmp_q[u_idx]    <= upd_is_jump;
            cnt_q[u_idx]    <= cnt_d;
        end else if (upd_acc && u_hit) begin
            cnt_q[u_idx] <= cnt_d;
        end
    end

`ifdef BTP_STATS_EN
    logic [31:0] upd_cnt_q, mis_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else if (upd_acc) begin
            if (upd_cnt_q != '1) upd_cnt_q <= upd_cnt_q + 32'd1;
            if (upd_mispredict && mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end

    assign stat_updates     = upd_cnt_q;
    assign stat_mispredicts = mis_cnt_q;
`else
    assign stat_updates     = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

    // Bits that carry no information for this table geometry.
    logic unused_ok;
    assign unused_ok = ^{upd_pc, upd_target[1:0], upd_mispredict};
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: directed scoreboard bench for branch_target_predictor.
module tb_branch_target_predictor;
    logic        clk = 1'b0, rst_n = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
    logic [31:0] if_pc = 32'h100;
    logic        pred_hit, pred_taken;
    logic [31:0] next_pc, stat_updates, stat_mispredicts;
    logic        upd_valid = 1'b0, upd_taken = 1'b0, upd_is_jump = 1'b0, upd_mispredict = 1'b0;
    logic [31:0] upd_pc = '0, upd_target = '0;

    branch_target_predictor dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .if_pc(if_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .next_pc(next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_is_jump(upd_is_jump),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        hit, taken;
        logic [31:0] npc, su, sm;
    } exp_t;
    exp_t q[$];

    int          tests = 0, fails = 0;
    logic        probe = 1'b0;
    logic [31:0] exp_su = '0, exp_sm = '0;
    logic        pend_u = 1'b0, pend_m = 1'b0;

    always @(negedge clk) begin
        if (probe) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL no_expect: probe with empty scoreboard at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({pred_hit, pred_taken, next_pc, stat_updates, stat_mispredicts} !==
                    {e.hit, e.taken, e.npc, e.su, e.sm}) begin
                    fails++;
                    $display("FAIL %s: got hit=%b taken=%b npc=%h su=%0d sm=%0d, want hit=%b taken=%b npc=%h su=%0d sm=%0d",
                             e.name, pred_hit, pred_taken, next_pc, stat_updates, stat_mispredicts,
                             e.hit, e.taken, e.npc, e.su, e.sm);
                end
            end
        end
    end

    task automatic drive(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic uj, input logic [31:0] utg,
                         input logic um, input logic st, input logic fl);
        @(posedge clk); #1;
        exp_su = exp_su + {31'd0, pend_u};
        exp_sm = exp_sm + {31'd0, pend_m};
        rst_n = 1'b1; probe = 1'b0;
        if_pc = pc; upd_valid = uv; upd_pc = upd_pc_or(upc); upd_taken = ut; upd_is_jump = uj;
        upd_target = utg; upd_mispredict = um; stall_i = st; flush_i = fl;
        pend_u = uv && !st && !fl;
        pend_m = pend_u && um;
    endtask

    function automatic logic [31:0] upd_pc_or(input logic [31:0] p);
        return p;
    endfunction

    task automatic look(input logic [31:0] pc);
        drive(pc, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic rst(input logic [31:0] pc);
        @(posedge clk); #1;
        rst_n = 1'b0; probe = 1'b0;
        exp_su = '0; exp_sm = '0; pend_u = 1'b0; pend_m = 1'b0;
        if_pc = pc; upd_valid = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic chk(input string nm, input logic h, input logic t, input logic [31:0] npc);
        exp_t e;
        e.name = nm; e.hit = h; e.taken = t; e.npc = npc;
`ifdef BTP_STATS_EN
        e.su = exp_su; e.sm = exp_sm;
`else
        e.su = '0; e.sm = '0;
`endif
        q.push_back(e);
        probe = 1'b1;
    endtask

    initial begin
        rst(32'h100);                                    chk("reset", 0, 0, 32'h104);
        drive(32'h100, 1, 32'h100, 1, 0, 32'h200, 1, 0, 0); chk("same_cycle_alloc", 0, 0, 32'h104);
        look(32'h100);                                   chk("alloc_hit", 1, 1, 32'h200);
        drive(32'h100, 1, 32'h100, 1, 0, 32'h200, 0, 0, 0);
        drive(32'h100, 1, 32'h100, 1, 0, 32'h200, 0, 0, 0);
        drive(32'h100, 1, 32'h100, 0, 0, 32'h0, 1, 0, 0);   chk("cnt_sat3", 1, 1, 32'h200);
        look(32'h100);                                   chk("cnt2", 1, 1, 32'h200);
        drive(32'h100, 1, 32'h100, 0, 0, 32'h0, 0, 0, 0);
        look(32'h100);                                   chk("cnt1", 1, 0, 32'h104);
        drive(32'h100, 1, 32'h100, 0, 0, 32'h0, 0, 0, 0);
        drive(32'h100, 1, 32'h100, 0, 0, 32'h0, 0, 0, 0);
        drive(32'h100, 1, 32'h100, 1, 0, 32'h200, 0, 0, 0);
        look(32'h100);                                   chk("cnt_floor", 1, 0, 32'h104);
        drive(32'h100, 1, 32'h100, 1, 0, 32'h200, 0, 0, 0);
        look(32'h100);                                   chk("cnt_rise", 1, 1, 32'h200);
        look(32'h140);                                   chk("alias_miss", 0, 0, 32'h144);
        drive(32'h140, 1, 32'h140, 1, 0, 32'h300, 1, 0, 0);
        look(32'h140);                                   chk("alias_hit", 1, 1, 32'h300);
        look(32'h100);                                   chk("alias_evict", 0, 0, 32'h104);
        drive(32'h140, 1, 32'h100, 0, 0, 32'h0, 0, 0, 0);
        look(32'h140);                                   chk("miss_not_taken", 1, 1, 32'h300);
        drive(32'h100, 1, 32'h100, 1, 0, 32'h500, 1, 1, 0);
        look(32'h100);                                   chk("stall_update", 0, 0, 32'h104);
        drive(32'h140, 0, 32'h0, 0, 0, 32'h0, 0, 1, 1);
        look(32'h140);                                   chk("stall_flush", 1, 1, 32'h300);
        drive(32'h140, 1, 32'h140, 0, 0, 32'h0, 0, 0, 0);   chk("read_old", 1, 1, 32'h300);
        look(32'h140);                                   chk("read_new", 1, 0, 32'h144);
        drive(32'h204, 1, 32'h204, 1, 1, 32'h600, 0, 0, 0);
        look(32'h204);                                   chk("jump_alloc", 1, 1, 32'h600);
        drive(32'h140, 1, 32'h180, 1, 1, 32'h400, 1, 0, 1);
        look(32'h140);                                   chk("flush_a", 0, 0, 32'h144);
        look(32'h204);                                   chk("flush_b", 0, 0, 32'h208);
        look(32'h180);                                   chk("flush_drop", 0, 0, 32'h184);
        drive(32'h180, 1, 32'h180, 1, 1, 32'h400, 0, 0, 0);
        look(32'h180);                                   chk("jump_hit", 1, 1, 32'h400);
        drive(32'h180, 1, 32'h180, 0, 0, 32'h0, 0, 0, 0);
        drive(32'h180, 1, 32'h180, 0, 0, 32'h0, 1, 0, 0);
        look(32'h180);                                   chk("jmp_flag", 1, 1, 32'h400);
        look(32'hFFFF_FFFC);                             chk("pc_wrap", 0, 0, 32'h0);
        rst(32'h180);                                    chk("async_reset", 0, 0, 32'h184);
        look(32'h180);                                   chk("post_reset", 0, 0, 32'h184);
        @(posedge clk); #1;
        probe = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
